qdma_h2c_stream_sink: RTL

User-side receiver for the QDMA H2C AXI-Stream: the slave end of the 512-bit H2C stream that the DMA drives. It accepts beats under programmable backpressure and checks framing, tkeep contiguity, byte parity and a deterministic payload pattern. It also maintains per-run packet, byte and error counters for the example design's status registers and test harness.

---
 rtl/qdma_h2c_sink_pkg.sv | 33 +++
 rtl/qdma_h2c_stream_sink_lfsr.sv | 29 ++
 rtl/qdma_h2c_stream_sink.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/qdma_h2c_sink_pkg.sv
// qdma_h2c_sink_pkg: shared types, constants and helpers for the H2C sink.
// The sink's optional parity check is enabled by H2C_SINK_PARITY_CHK_EN.
`ifndef XDMA_H2C_TUSER_WIDTH
`define XDMA_H2C_TUSER_WIDTH 16
`endif

package qdma_h2c_sink_pkg;

  localparam int SINK_DATA_W = 512;
  localparam int LANES       = SINK_DATA_W / 8;
  localparam int POP_W       = $clog2(LANES + 1);

  localparam int ERR_KEEP = 0;
  localparam int ERR_PAR  = 1;
  localparam int ERR_DATA = 2;
  localparam int ERR_QID  = 3;

  // Fibonacci taps 16,14,13,11 as a mask over lfsr[15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    S_SOP,
    S_MOP
  } state_e;

  function automatic logic [POP_W-1:0] popcnt(input logic [LANES-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) n = n + POP_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/qdma_h2c_stream_sink_lfsr.sv
// qdma_lfsr_throttle: 16-bit Fibonacci LFSR giving one backpressure bit.
// A zero seed is replaced by 1 so the register can never lock up.
module qdma_lfsr_throttle
  import qdma_h2c_sink_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [15:0] i_seed,
  output logic        o_thr
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb  = ^(r_lfsr & LFSR_TAPS);
  assign o_thr = r_lfsr[0];

  // Load seed on clear, otherwise advance every cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_lfsr <= 16'h0001;
    else if (i_load)
      r_lfsr <= (i_seed == 16'h0000) ? 16'h0001 : i_seed;
    else
      r_lfsr <= {r_lfsr[14:0], w_fb};
  end

endmodule

// File: rtl/qdma_h2c_stream_sink.sv
// qdma_h2c_stream_sink: H2C AXI-Stream slave with framing/data checks.
// Define H2C_SINK_PARITY_CHK_EN to enable the per-byte parity check.
module qdma_h2c_stream_sink
  import qdma_h2c_sink_pkg::*;
#(
  parameter int DATA_W  = 512,
  parameter int TUSER_W = `XDMA_H2C_TUSER_WIDTH,
  parameter int CNT_W   = 32
) (
  input  logic                axi_aclk,
  input  logic                axi_aresetn,
  input  logic [DATA_W-1:0]   tdata,
  input  logic [DATA_W/8-1:0] tparity,
  input  logic                tlast,
  input  logic                tvalid,
  input  logic [DATA_W/8-1:0] tkeep,
  input  logic [TUSER_W-1:0]  tusr,
  output logic                tready,
  input  logic                sink_en,
  input  logic                thr_en,
  input  logic [15:0]         thr_seed,
  input  logic                clr,
  output logic [CNT_W-1:0]    pkt_cnt,
  output logic [CNT_W-1:0]    byte_cnt,
  output logic [15:0]         err_cnt,
  output logic [3:0]          err_sticky,
  output logic [10:0]         last_qid,
  output logic                err_pulse
);

  localparam int NB = DATA_W / 8;

  state_e           r_state;
  logic [7:0]       r_beat;
  logic [10:0]      r_qid;
  logic             r_c_vld;
  logic             r_c_last;
  logic [3:0]       r_c_flags;
  logic [10:0]      r_c_qid;
  logic [POP_W-1:0] r_c_bytes;
  logic [3:0]       r_pkt_flags;
  logic [CNT_W-1:0] r_pkt_cnt;
  logic [CNT_W-1:0] r_byte_cnt;
  logic [15:0]      r_err_cnt;
  logic [3:0]       r_sticky;
  logic [10:0]      r_last_qid;
  logic             r_err_pulse;

  logic             w_thr;
  logic             w_rdy;
  logic             w_acc;
  logic             w_keep_err;
  logic             w_data_err;
  logic             w_par_err;
  logic             w_qid_err;
  logic [3:0]       w_flags;
  logic [3:0]       w_tot;
  logic [CNT_W:0]   w_byte_sum;
  logic             w_unused_tusr;

  qdma_lfsr_throttle u_thr (
    .i_clk   (axi_aclk),
    .i_rst_n (axi_aresetn),
    .i_load  (clr),
    .i_seed  (thr_seed),
    .o_thr   (w_thr)
  );

  assign w_rdy  = axi_aresetn & sink_en & ~clr & (~thr_en | w_thr);
  assign tready = w_rdy;
  assign w_acc  = tvalid & w_rdy;

  assign w_unused_tusr = ^tusr[TUSER_W-1:11];

  assign w_keep_err = tlast
    ? ((tkeep == '0) || ((tkeep & (tkeep + NB'(1))) != '0))
    : (tkeep != '1);

  assign w_qid_err = (r_state == S_MOP) && (tusr[10:0] != r_qid);

  // Pattern compare on kept lanes: byte i of beat b is (b*NB + i) mod 256
  always_comb begin
    w_data_err = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (tkeep[i] && (tdata[8*i+:8] != 8'(int'(r_beat) * NB + i)))
        w_data_err = 1'b1;
    end
  end

`ifdef H2C_SINK_PARITY_CHK_EN
  // Even parity per kept byte
  always_comb begin
    w_par_err = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (tkeep[i] && (tparity[i] != ^tdata[8*i+:8]))
        w_par_err = 1'b1;
    end
  end
`else
  logic w_unused_par;
  assign w_unused_par = ^tparity;
  assign w_par_err    = 1'b0;
`endif

  // Gather per-beat error flags by bit index
  always_comb begin
    w_flags           = '0;
    w_flags[ERR_KEEP] = w_keep_err;
    w_flags[ERR_PAR]  = w_par_err;
    w_flags[ERR_DATA] = w_data_err;
    w_flags[ERR_QID]  = w_qid_err;
  end

  // Framing FSM and compare stage register
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_state   <= S_SOP;
      r_beat    <= '0;
      r_qid     <= '0;
      r_c_vld   <= 1'b0;
      r_c_last  <= 1'b0;
      r_c_flags <= '0;
      r_c_qid   <= '0;
      r_c_bytes <= '0;
    end else if (clr) begin
      r_state <= S_SOP;
      r_beat  <= '0;
      r_c_vld <= 1'b0;
    end else begin
      r_c_vld <= w_acc;
      if (w_acc) begin
        r_c_last  <= tlast;
        r_c_flags <= w_flags;
        r_c_qid   <= tusr[10:0];
        r_c_bytes <= popcnt(tkeep);
        if (r_state == S_SOP) r_qid <= tusr[10:0];
        r_state <= tlast ? S_SOP : S_MOP;
        r_beat  <= tlast ? 8'd0 : r_beat + 8'd1;
      end
    end
  end

  assign w_tot      = r_pkt_flags | r_c_flags;
  assign w_byte_sum = {1'b0, r_byte_cnt} + (CNT_W + 1)'(r_c_bytes);

  // Commit stage: saturating counters and per-packet status
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_pkt_flags <= '0;
      r_pkt_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_err_cnt   <= '0;
      r_sticky    <= '0;
      r_last_qid  <= '0;
      r_err_pulse <= 1'b0;
    end else if (clr) begin
      r_pkt_flags <= '0;
      r_pkt_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_err_cnt   <= '0;
      r_sticky    <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      r_err_pulse <= 1'b0;
      if (r_c_vld) begin
        r_byte_cnt <= w_byte_sum[CNT_W] ? '1 : w_byte_sum[CNT_W-1:0];
        if (r_c_last) begin
          r_pkt_flags <= '0;
          r_last_qid  <= r_c_qid;
          if (r_pkt_cnt != '1) r_pkt_cnt <= r_pkt_cnt + 1'b1;
          if (|w_tot) begin
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
            r_err_pulse <= 1'b1;
            r_sticky    <= r_sticky | w_tot;
          end
        end else begin
          r_pkt_flags <= w_tot;
        end
      end
    end
  end

  assign pkt_cnt    = r_pkt_cnt;
  assign byte_cnt   = r_byte_cnt;
  assign err_cnt    = r_err_cnt;
  assign err_sticky = r_sticky;
  assign last_qid   = r_last_qid;
  assign err_pulse  = r_err_pulse;

endmodule
